// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package riscv_boot_pkg;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      StLenLo,
      StLenHi,
      StData,
      StWrite,
      StDone,
      StErr
   } boot_state_e;

   // Stream header is a 16-bit little-endian word count.
   localparam int unsigned BOOT_LEN_BYTES = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the first byte lands in [7:0].
module boot_byte_packer
   import riscv_boot_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   localparam int unsigned CntW = $clog2(BYTES_PER_WORD);
   localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_WORD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     word_q, word_d;

   // Shift new bytes in from the top so four pushes leave byte 0 at [7:0].
   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (push_i) begin
         word_d = {byte_i, word_q[31:8]};
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // The byte that completes a word is flagged in the same cycle it is pushed.
   always_comb begin
      word_full_o = push_i && !clear_i && (cnt_q == LastCnt);
      word_o      = word_q;
   end

   // Counter and packing register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes instruction memory
// from word 0 and holds the core in reset until the whole program is in place.
module imem_boot_loader
   import riscv_boot_pkg::*;
#(
   parameter int unsigned DW             = 32,
   parameter int unsigned MEM_SIZE_IN_KB = 1,
   parameter int unsigned NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
   parameter int unsigned ADDRW          = $clog2(NO_OF_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   output logic             byte_ready_o,
   output logic             imem_we_o,
   output logic [ADDRW-1:0] imem_addr_o,
   output logic [DW-1:0]    imem_wdata_o,
   output logic             core_rst_o,
   output logic             done_o,
   output logic             err_o
);

   boot_state_e state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] len_full;
   logic        accept;
   logic        pack_clear;
   logic        word_full;
   logic [31:0] packed_word;

   assign accept     = byte_valid_i && byte_ready_o;
   // Only DATA feeds the packer; elsewhere keep the byte counter parked at zero.
   assign pack_clear = (state_q != StData);
   assign len_full   = {byte_i, len_q[7:0]};

   boot_byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept),
      .clear_i     (pack_clear),
      .byte_i      (byte_i),
      .word_o      (packed_word),
      .word_full_o (word_full)
   );

   // Next-state, length capture and word-index advance.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      unique case (state_q)
         StLenLo: begin
            if (accept) begin
               len_d[7:0] = byte_i;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d[15:8] = byte_i;
               if (len_full == 16'd0) begin
                  state_d = StDone;
               end else if ({16'd0, len_full} > NO_OF_REGS) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (word_full) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            idx_d = idx_q + 16'd1;
            if (idx_q == (len_q - 16'd1)) begin
               state_d = StDone;
            end else begin
               state_d = StData;
            end
         end
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StLenLo;
      endcase
   end

   // Outputs decode from registered state only.
   always_comb begin
      byte_ready_o = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
      imem_we_o    = (state_q == StWrite);
      core_rst_o   = (state_q != StDone);
      done_o       = (state_q == StDone);
      err_o        = (state_q == StErr);
      imem_addr_o  = idx_q[ADDRW-1:0];
      imem_wdata_o = DW'(packed_word);
   end

   // State, length and index registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StLenLo;
         len_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized loads.
module tb_imem_boot_loader;

   localparam int unsigned DW     = 32;
   localparam int unsigned NREGS  = 256;
   localparam int unsigned ADDRW  = 8;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             byte_valid_i;
   logic [7:0]       byte_i;
   logic             byte_ready_o;
   logic             imem_we_o;
   logic [ADDRW-1:0] imem_addr_o;
   logic [DW-1:0]    imem_wdata_o;
   logic             core_rst_o;
   logic             done_o;
   logic             err_o;

   int total = 0;
   int bad   = 0;

   // Observed memory image and write statistics.
   logic [31:0] tb_mem [0:NREGS-1];
   int          wr_cnt = 0;
   int          zero_wr = 0;
   logic [ADDRW-1:0] last_addr;
   logic [31:0]      last_data;

   imem_boot_loader #(
      .DW             (DW),
      .MEM_SIZE_IN_KB (1)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_wdata_o (imem_wdata_o),
      .core_rst_o   (core_rst_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Capture write strobes away from the active edge.
   always @(negedge clk_i) begin
      if (imem_we_o === 1'b1) begin
         tb_mem[imem_addr_o] = imem_wdata_o;
         wr_cnt++;
         if (imem_addr_o == '0) zero_wr++;
         last_addr = imem_addr_o;
         last_data = imem_wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Offer one byte after a random gap; returns at the negedge following its transfer.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int waited;
      gap = int'($urandom_range(max_gap, 0));
      if (gap > 0) begin
         byte_valid_i = 1'b0;
         repeat (gap) @(negedge clk_i);
      end
      byte_valid_i = 1'b1;
      byte_i = b;
      waited = 0;
      while (byte_ready_o !== 1'b1 && waited < 20) begin
         // Mid-load, the only stall is the write cycle.
         chk("ready_low_only_in_write", {31'd0, imem_we_o}, 32'd1);
         @(negedge clk_i);
         waited++;
      end
      if (waited >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk_i);
   endtask

   // Build the stream from words with arithmetic: length LE, then each word LE.
   task automatic send_program(input logic [31:0] words [$], input int max_gap);
      int n;
      n = words.size();
      send_byte(8'(n & 'hFF), max_gap);
      send_byte(8'((n >> 8) & 'hFF), max_gap);
      foreach (words[i]) begin
         for (int b = 0; b < 4; b++) send_byte(8'((words[i] >> (8 * b)) & 32'hFF), max_gap);
      end
      byte_valid_i = 1'b0;
   endtask

   // After the final data byte: one write cycle, then release.
   task automatic check_release(input string tag);
      chk({tag, "_final_we"}, {31'd0, imem_we_o}, 32'd1);
      chk({tag, "_core_held_during_write"}, {31'd0, core_rst_o}, 32'd1);
      @(negedge clk_i);
      #1;
      chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
      chk({tag, "_core_released"}, {31'd0, core_rst_o}, 32'd0);
      chk({tag, "_we_low"}, {31'd0, imem_we_o}, 32'd0);
      chk({tag, "_ready_low"}, {31'd0, byte_ready_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] prog [$];
      logic [7:0]  part [$];
      int base;
      int zbase;
      int n;

      rst_i = 1'b1;
      byte_valid_i = 1'b0;
      byte_i = 8'h00;

      // Reset values.
      @(negedge clk_i);
      chk("rst_ready", {31'd0, byte_ready_o}, 32'd1);
      chk("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
      chk("rst_we", {31'd0, imem_we_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr_o}, 32'd0);
      chk("rst_wdata", imem_wdata_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Normal load at full rate.
      base = wr_cnt;
      prog = '{32'h00A00513, 32'h00500593};
      send_program(prog, 0);
      check_release("normal");
      chk("normal_word0", tb_mem[0], 32'h00A00513);
      chk("normal_word1", tb_mem[1], 32'h00500593);
      chk("normal_write_count", 32'(wr_cnt - base), 32'd2);

      // Empty program.
      do_reset();
      base = wr_cnt;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      byte_valid_i = 1'b0;
      chk("empty_done", {31'd0, done_o}, 32'd1);
      chk("empty_core_rst", {31'd0, core_rst_o}, 32'd0);
      chk("empty_ready", {31'd0, byte_ready_o}, 32'd0);
      repeat (3) @(negedge clk_i);
      chk("empty_no_writes", 32'(wr_cnt - base), 32'd0);

      // Oversize length 257.
      do_reset();
      base = wr_cnt;
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("over_err", {31'd0, err_o}, 32'd1);
      chk("over_core_rst", {31'd0, core_rst_o}, 32'd1);
      chk("over_ready", {31'd0, byte_ready_o}, 32'd0);
      byte_valid_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         byte_i = 8'($urandom);
         @(negedge clk_i);
      end
      byte_valid_i = 1'b0;
      chk("over_still_err", {31'd0, err_o}, 32'd1);
      chk("over_no_done", {31'd0, done_o}, 32'd0);
      chk("over_no_writes", 32'(wr_cnt - base), 32'd0);

      // Gappy valid, same program.
      do_reset();
      base = wr_cnt;
      tb_mem[0] = 32'hDEAD_BEEF;
      tb_mem[1] = 32'hDEAD_BEEF;
      prog = '{32'h00A00513, 32'h00500593};
      send_program(prog, 3);
      check_release("gappy");
      chk("gappy_word0", tb_mem[0], 32'h00A00513);
      chk("gappy_word1", tb_mem[1], 32'h00500593);
      chk("gappy_write_count", 32'(wr_cnt - base), 32'd2);

      // Reset asserted mid-load after five bytes.
      do_reset();
      base = wr_cnt;
      part = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};
      foreach (part[i]) send_byte(part[i], 0);
      byte_valid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, byte_ready_o}, 32'd1);
      chk("midrst_core_rst", {31'd0, core_rst_o}, 32'd1);
      chk("midrst_we", {31'd0, imem_we_o}, 32'd0);
      chk("midrst_done", {31'd0, done_o}, 32'd0);
      chk("midrst_addr", {24'd0, imem_addr_o}, 32'd0);
      chk("midrst_wdata", imem_wdata_o, 32'd0);
      chk("midrst_no_writes", 32'(wr_cnt - base), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      prog = '{32'h11223344, 32'hA5A55A5A};
      send_program(prog, 1);
      check_release("reload");
      chk("reload_word0", tb_mem[0], 32'h11223344);
      chk("reload_word1", tb_mem[1], 32'hA5A55A5A);
      chk("reload_write_count", 32'(wr_cnt - base), 32'd2);

      // Randomized programs.
      for (int t = 0; t < 4; t++) begin
         do_reset();
         base = wr_cnt;
         n = int'($urandom_range(8, 1));
         prog.delete();
         for (int i = 0; i < n; i++) prog.push_back($urandom);
         send_program(prog, 3);
         check_release("rand");
         for (int i = 0; i < n; i++) chk("rand_word", tb_mem[i], prog[i]);
         chk("rand_write_count", 32'(wr_cnt - base), 32'(n));
      end

      // Full depth, word i = i.
      do_reset();
      base = wr_cnt;
      zbase = zero_wr;
      prog.delete();
      for (int i = 0; i < int'(NREGS); i++) prog.push_back(32'(i));
      send_program(prog, 0);
      check_release("full");
      chk("full_last_addr", {24'd0, last_addr}, 32'd255);
      chk("full_last_data", last_data, 32'h000000FF);
      chk("full_write_count", 32'(wr_cnt - base), 32'd256);
      chk("full_addr0_once", 32'(zero_wr - zbase), 32'd1);
      for (int i = 0; i < int'(NREGS); i += 37) chk("full_word", tb_mem[i], 32'(i));
      repeat (4) @(negedge clk_i);
      chk("full_no_extra_writes", 32'(wr_cnt - base), 32'd256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequence stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
